// File: rtl/lc3_decode_stage.sv
// LC3 decode stage: registers the fetched instruction and its npc, and decodes
// the opcode into execute, writeback and memory-access control fields.
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   enable_decode          1 = latch dout/npc_in and its decode on this edge
//   dout, npc_in           fetched instruction word and its PC+1
//   IR, npc_out            registered instruction and npc
//   E_Control              {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
//   W_Control              00 ALU result, 01 memory data, 10 computed PC
//   Mem_Control            1 = indirect access (LDI/STI)
//   decode_valid           1 once a non-reset decode has been latched
//   illegal_op             latched opcode is unsupported (when ILLEGAL_EN=1)
module lc3_decode_stage #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter bit          ILLEGAL_EN = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable_decode,
  input  logic [DATA_WIDTH-1:0] dout,
  input  logic [DATA_WIDTH-1:0] npc_in,
  output logic [DATA_WIDTH-1:0] IR,
  output logic [DATA_WIDTH-1:0] npc_out,
  output logic [5:0]            E_Control,
  output logic [1:0]            W_Control,
  output logic                  Mem_Control,
  output logic                  decode_valid,
  output logic                  illegal_op
);

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_BR  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OPC_W-1:0] OP_LD  = 4'b0010;
  localparam logic [OPC_W-1:0] OP_ST  = 4'b0011;
  localparam logic [OPC_W-1:0] OP_AND = 4'b0101;
  localparam logic [OPC_W-1:0] OP_LDR = 4'b0110;
  localparam logic [OPC_W-1:0] OP_STR = 4'b0111;
  localparam logic [OPC_W-1:0] OP_NOT = 4'b1001;
  localparam logic [OPC_W-1:0] OP_LDI = 4'b1010;
  localparam logic [OPC_W-1:0] OP_STI = 4'b1011;
  localparam logic [OPC_W-1:0] OP_JMP = 4'b1100;
  localparam logic [OPC_W-1:0] OP_LEA = 4'b1110;

  // W_Control encodings
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  // Common E_Control pattern for PC-relative offset9 addressing: pcs1=01, pcs2=npc
  localparam logic [5:0] E_PCREL9 = 6'b00_01_1_0;

  logic [OPC_W-1:0] opcode;
  logic [5:0]       e_ctrl_c;
  logic [1:0]       w_ctrl_c;
  logic             mem_ctrl_c;
  logic             illegal_c;

  assign opcode = dout[DATA_WIDTH-1 -: OPC_W];

  // Opcode decode; unsupported opcodes fall to the NOP default
  always_comb begin
    e_ctrl_c   = 6'b0;
    w_ctrl_c   = WB_ALU;
    mem_ctrl_c = 1'b0;
    illegal_c  = 1'b0;
    unique case (opcode)
      // op2select=1 picks VSR2; imm5 form (dout[5]=1) clears it
      OP_ADD: e_ctrl_c = {2'b00, 2'b00, 1'b0, ~dout[5]};
      OP_AND: e_ctrl_c = {2'b01, 2'b00, 1'b0, ~dout[5]};
      OP_NOT: e_ctrl_c = 6'b10_00_0_1;
      OP_BR:  e_ctrl_c = E_PCREL9;
      OP_JMP: e_ctrl_c = 6'b00_11_0_0;
      OP_LD: begin
        e_ctrl_c = E_PCREL9;
        w_ctrl_c = WB_MEM;
      end
      OP_LDI: begin
        e_ctrl_c   = E_PCREL9;
        w_ctrl_c   = WB_MEM;
        mem_ctrl_c = 1'b1;
      end
      OP_LEA: begin
        e_ctrl_c = E_PCREL9;
        w_ctrl_c = WB_PC;
      end
      OP_ST:  e_ctrl_c = E_PCREL9;
      OP_STI: begin
        e_ctrl_c   = E_PCREL9;
        mem_ctrl_c = 1'b1;
      end
      OP_LDR: begin
        e_ctrl_c = 6'b00_10_0_0;
        w_ctrl_c = WB_MEM;
      end
      OP_STR: e_ctrl_c = 6'b00_10_0_0;
      default: illegal_c = ILLEGAL_EN;
    endcase
  end

  // Pipeline register: reset wins over enable; enable low holds everything
  always_ff @(posedge clock) begin
    if (reset) begin
      IR           <= '0;
      npc_out      <= '0;
      E_Control    <= '0;
      W_Control    <= '0;
      Mem_Control  <= 1'b0;
      decode_valid <= 1'b0;
      illegal_op   <= 1'b0;
    end else if (enable_decode) begin
      IR           <= dout;
      npc_out      <= npc_in;
      E_Control    <= e_ctrl_c;
      W_Control    <= w_ctrl_c;
      Mem_Control  <= mem_ctrl_c;
      decode_valid <= 1'b1;
      illegal_op   <= illegal_c;
    end
  end

endmodule

// File: tb/tb_lc3_decode_stage.sv
// Directed bench for lc3_decode_stage: reset, per-opcode decode, stall hold,
// illegal opcodes (with and without ILLEGAL_EN) and reset overriding enable.
module tb_lc3_decode_stage;

  logic        clock;
  logic        reset;
  logic        enable_decode;
  logic [15:0] dout;
  logic [15:0] npc_in;

  logic [15:0] ir, npc_out;
  logic [5:0]  e_control;
  logic [1:0]  w_control;
  logic        mem_control, decode_valid, illegal_op;

  logic [15:0] ir0, npc_out0;
  logic [5:0]  e_control0;
  logic [1:0]  w_control0;
  logic        mem_control0, decode_valid0, illegal_op0;

  int checks = 0;
  int errors = 0;

  lc3_decode_stage #(.DATA_WIDTH(16), .ILLEGAL_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .enable_decode(enable_decode),
    .dout(dout), .npc_in(npc_in),
    .IR(ir), .npc_out(npc_out), .E_Control(e_control), .W_Control(w_control),
    .Mem_Control(mem_control), .decode_valid(decode_valid), .illegal_op(illegal_op)
  );

  // Second instance with illegal-opcode reporting disabled
  lc3_decode_stage #(.DATA_WIDTH(16), .ILLEGAL_EN(1'b0)) dut_noill (
    .clock(clock), .reset(reset), .enable_decode(enable_decode),
    .dout(dout), .npc_in(npc_in),
    .IR(ir0), .npc_out(npc_out0), .E_Control(e_control0), .W_Control(w_control0),
    .Mem_Control(mem_control0), .decode_valid(decode_valid0), .illegal_op(illegal_op0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [15:0] e_ir, input logic [15:0] e_npc,
                           input logic [5:0] e_e, input logic [1:0] e_w, input logic e_m,
                           input logic e_v, input logic e_ill);
    check({tag, ".IR"},    ir,                     e_ir);
    check({tag, ".npc"},   npc_out,                e_npc);
    check({tag, ".E"},     16'(e_control),         16'(e_e));
    check({tag, ".W"},     16'(w_control),         16'(e_w));
    check({tag, ".M"},     16'(mem_control),       16'(e_m));
    check({tag, ".valid"}, 16'(decode_valid),      16'(e_v));
    check({tag, ".ill"},   16'(illegal_op),        16'(e_ill));
    check({tag, ".ill0"},  16'(illegal_op0),       16'h0);
    check({tag, ".E0"},    16'(e_control0),        16'(e_e));
  endtask

  // Latch one word and check its decode on the following edge
  task automatic apply(input string tag, input logic [15:0] d, input logic [15:0] npc,
                       input logic [5:0] e_e, input logic [1:0] e_w, input logic e_m,
                       input logic e_ill);
    enable_decode = 1'b1;
    dout          = d;
    npc_in        = npc;
    step();
    check_all(tag, d, npc, e_e, e_w, e_m, 1'b1, e_ill);
  endtask

  initial begin
    reset         = 1'b1;
    enable_decode = 1'b1;
    dout          = 16'h1042;
    npc_in        = 16'h3000;

    // Reset held for two edges with enable high
    step();
    step();
    check_all("reset", 16'h0, 16'h0, 6'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    apply("add_reg", 16'h1042, 16'h3001, 6'b000001, 2'b00, 1'b0, 1'b0);
    apply("ldr",     16'h6283, 16'h3002, 6'b001000, 2'b01, 1'b0, 1'b0);
    apply("ldi",     16'hA205, 16'h3003, 6'b000110, 2'b01, 1'b1, 1'b0);
    apply("and_imm", 16'h5020, 16'h3004, 6'b010000, 2'b00, 1'b0, 1'b0);

    // Stall: inputs change but nothing updates
    enable_decode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dout   = (i == 0) ? 16'hFFFF : (i == 1) ? 16'h1042 : 16'hD000;
      npc_in = 16'h4000 + 16'(i);
      step();
      check_all("stall", 16'h5020, 16'h3004, 6'b010000, 2'b00, 1'b0, 1'b1, 1'b0);
    end

    apply("illegal_d", 16'hD000, 16'h3005, 6'b0, 2'b00, 1'b0, 1'b1);
    enable_decode = 1'b0;
    dout          = 16'h1042;
    step();
    check_all("ill_hold", 16'hD000, 16'h3005, 6'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    apply("lea",     16'hE005, 16'h3006, 6'b000110, 2'b10, 1'b0, 1'b0);
    apply("jmp",     16'hC1C0, 16'h3007, 6'b001100, 2'b00, 1'b0, 1'b0);

    // Reset overrides an enabled word in the same cycle
    reset         = 1'b1;
    enable_decode = 1'b1;
    dout          = 16'h1042;
    npc_in        = 16'h3008;
    step();
    check_all("reset_mid", 16'h0, 16'h0, 6'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Remaining opcodes
    apply("br",        16'h0E05, 16'h3100, 6'b000110, 2'b00, 1'b0, 1'b0);
    apply("add_imm",   16'h1025, 16'h3101, 6'b000000, 2'b00, 1'b0, 1'b0);
    apply("ld",        16'h2405, 16'h3102, 6'b000110, 2'b01, 1'b0, 1'b0);
    apply("st",        16'h3405, 16'h3103, 6'b000110, 2'b00, 1'b0, 1'b0);
    apply("illegal_4", 16'h4000, 16'h3104, 6'b0,      2'b00, 1'b0, 1'b1);
    apply("and_reg",   16'h5042, 16'h3105, 6'b010001, 2'b00, 1'b0, 1'b0);
    apply("str",       16'h7283, 16'h3106, 6'b001000, 2'b00, 1'b0, 1'b0);
    apply("illegal_8", 16'h8000, 16'h3107, 6'b0,      2'b00, 1'b0, 1'b1);
    apply("not",       16'h903F, 16'h3108, 6'b100001, 2'b00, 1'b0, 1'b0);
    apply("sti",       16'hB205, 16'h3109, 6'b000110, 2'b00, 1'b1, 1'b0);
    apply("illegal_f", 16'hF025, 16'h310A, 6'b0,      2'b00, 1'b0, 1'b1);
    apply("ldi2",      16'hA3FF, 16'h310B, 6'b000110, 2'b01, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
